led_bank_mux: RTL

- Time-shares one common N-line LED drive bus among BANKS independent led_matrix instances. Each bank keeps private M-line select outputs.
- Arbitrates round-robin on each bank's done_tick, with programmable dead-time blanking between banks to suppress ghosting.
- Sits between the led_matrix instances and the G/D pad drivers in blastit_main.
- Generalises two-bank sharing to any bank count, with per-bank masking and frame reporting.

---
 rtl/led_bank_mux_if.sv | 41 ++++
 rtl/led_bank_mux.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/led_bank_mux_if.sv
// Bundle between the bank arbiter, the led_matrix banks and the G/D pad drivers.
// to_flags/to_clr exist only when LED_BANK_MUX_TIMEOUT_EN is defined.
interface led_bank_mux_if #(
  parameter int BANKS      = 4,
  parameter int SEL_BITS   = 2,
  parameter int N          = 10,
  parameter int M          = 3,
  parameter int BLANK_BITS = 8
);
  logic                  en;
  logic [BANKS-1:0]      bank_mask;
  logic [BLANK_BITS-1:0] blank_cycles;
  logic [BANKS*N-1:0]    bank_n_en;
  logic [BANKS*M-1:0]    bank_m_en;
  logic [BANKS-1:0]      bank_done_tick;
  logic [N-1:0]          n_en;
  logic [BANKS*M-1:0]    m_en;
  logic [BANKS-1:0]      bank_active;
  logic [SEL_BITS-1:0]   cur_bank;
  logic                  frame_tick;
`ifdef LED_BANK_MUX_TIMEOUT_EN
  logic [BANKS-1:0]      to_flags;
  logic                  to_clr;
`endif

  modport master (
    output en, bank_mask, blank_cycles, bank_n_en, bank_m_en, bank_done_tick,
    input  n_en, m_en, bank_active, cur_bank, frame_tick
`ifdef LED_BANK_MUX_TIMEOUT_EN
    , input to_flags, output to_clr
`endif
  );

  modport slave (
    input  en, bank_mask, blank_cycles, bank_n_en, bank_m_en, bank_done_tick,
    output n_en, m_en, bank_active, cur_bank, frame_tick
`ifdef LED_BANK_MUX_TIMEOUT_EN
    , output to_flags, input to_clr
`endif
  );
endinterface

// File: rtl/led_bank_mux.sv
// Round-robin time-sharing of one N-line drive bus among BANKS led_matrix banks with dead-time
// blanking. Define LED_BANK_MUX_TIMEOUT_EN to add a per-bank dwell timeout with sticky flags.
module led_bank_mux #(
  parameter int BANKS      = 4,
  parameter int SEL_BITS   = 2,
  parameter int N          = 10,
  parameter int M          = 3,
  parameter int BLANK_BITS = 8
`ifdef LED_BANK_MUX_TIMEOUT_EN
  , parameter int TO_BITS  = 16
`endif
) (
  input logic           clk,
  input logic           reset_n,
  led_bank_mux_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, BLANK = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [SEL_BITS-1:0]   cur_q, cur_d;
  logic [BLANK_BITS-1:0] blank_q, blank_d;
  logic                  frame_q, frame_d;
  logic [N-1:0]          n_en_q, n_en_d;
  logic [BANKS*M-1:0]    m_en_q, m_en_d;
  logic [BANKS-1:0]      active_q, active_d;
  logic                  advance, drive_d, tenure_end, timeout;
  logic [N-1:0]          n_slice [BANKS];

  function automatic logic [SEL_BITS-1:0] lowest_set(input logic [BANKS-1:0] mask);
    lowest_set = '0;
    for (int b = BANKS - 1; b >= 0; b--)
      if (mask[b]) lowest_set = SEL_BITS'(b);
  endfunction

  // Returns {wrapped, index}: first participating bank above cur, else wrap to the lowest one.
  function automatic logic [SEL_BITS:0] next_sel(input logic [BANKS-1:0] mask,
                                                 input logic [SEL_BITS-1:0] cur);
    logic                found;
    logic [SEL_BITS-1:0] hi;
    found = 1'b0;
    hi    = '0;
    for (int b = BANKS - 1; b >= 0; b--)
      if (mask[b] && (b > int'(cur))) begin
        found = 1'b1;
        hi    = SEL_BITS'(b);
      end
    next_sel = found ? {1'b0, hi} : {1'b1, lowest_set(mask)};
  endfunction

  // Losing its mask bit ends a bank's tenure exactly like its own done_tick.
  assign tenure_end = bus.bank_done_tick[cur_q] || !bus.bank_mask[cur_q];

`ifdef LED_BANK_MUX_TIMEOUT_EN
  logic [TO_BITS-1:0] dwell_q, dwell_d;
  logic [BANKS-1:0]   flags_q, flags_d;

  assign timeout = (state_q == DRIVE) && (dwell_q == {{(TO_BITS - 1){1'b1}}, 1'b0});
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    blank_d = blank_q;
    frame_d = 1'b0;
    advance = 1'b0;
    if (!bus.en || bus.bank_mask == '0) begin
      state_d = IDLE;
      blank_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DRIVE;
          cur_d   = lowest_set(bus.bank_mask);
        end
        DRIVE: begin
          if (tenure_end || timeout) begin
            advance          = 1'b1;
            {frame_d, cur_d} = next_sel(bus.bank_mask, cur_q);
            if (bus.blank_cycles != '0) begin
              state_d = BLANK;
              blank_d = bus.blank_cycles;
            end
          end
        end
        BLANK: begin
          if (blank_q > BLANK_BITS'(1)) begin
            blank_d = blank_q - BLANK_BITS'(1);
          end else begin
            state_d = DRIVE;
            blank_d = '0;
            // Target lost its mask bit while blanking: skip it without a second gap.
            if (!bus.bank_mask[cur_q]) {frame_d, cur_d} = next_sel(bus.bank_mask, cur_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef LED_BANK_MUX_TIMEOUT_EN
  always_comb begin
    dwell_d = '0;
    if (state_d == DRIVE && state_q == DRIVE && !advance) dwell_d = dwell_q + TO_BITS'(1);
    flags_d = bus.to_clr ? '0 : flags_q;
    if (advance && !tenure_end) flags_d[cur_q] = 1'b1;
  end
`endif

  assign drive_d = (state_d == DRIVE);

  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    assign n_slice[gi]        = bus.bank_n_en[gi*N +: N];
    assign active_d[gi]       = drive_d && (cur_d == SEL_BITS'(gi));
    assign m_en_d[gi*M +: M]  = active_d[gi] ? bus.bank_m_en[gi*M +: M] : '0;
  end

  assign n_en_d = drive_d ? n_slice[cur_d] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      blank_q  <= '0;
      frame_q  <= 1'b0;
      n_en_q   <= '0;
      m_en_q   <= '0;
      active_q <= '0;
`ifdef LED_BANK_MUX_TIMEOUT_EN
      dwell_q  <= '0;
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      blank_q  <= blank_d;
      frame_q  <= frame_d;
      n_en_q   <= n_en_d;
      m_en_q   <= m_en_d;
      active_q <= active_d;
`ifdef LED_BANK_MUX_TIMEOUT_EN
      dwell_q  <= dwell_d;
      flags_q  <= flags_d;
`endif
    end
  end

  assign bus.n_en        = n_en_q;
  assign bus.m_en        = m_en_q;
  assign bus.bank_active = active_q;
  assign bus.cur_bank    = cur_q;
  assign bus.frame_tick  = frame_q;
`ifdef LED_BANK_MUX_TIMEOUT_EN
  assign bus.to_flags    = flags_q;
`endif
endmodule
